// File: rtl/dmem_mmio_pkg.sv
// Shared types and helpers for the RV32I data memory: access sizes, MMIO register
// offsets, and the lane steering used by loads and stores.
package dmem_mmio_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  localparam logic [3:0] OFF_TOHOST = 4'h0;
  localparam logic [3:0] OFF_TXDATA = 4'h4;
  localparam logic [3:0] OFF_TXSTAT = 4'h8;
  localparam logic [3:0] OFF_CYCLES = 4'hC;

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  addr_lo,
                                              input size_t       size,
                                              input logic        is_unsigned);
    logic [31:0] sh;
    sh = word >> {addr_lo, 3'b000};
    case (size)
      SZ_BYTE: return is_unsigned ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: return is_unsigned ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

  // Returns {byte_enables[3:0], lane_data[31:0]} with the store data replicated.
  function automatic logic [35:0] store_lanes(input logic [31:0] wdata,
                                              input logic [1:0]  addr_lo,
                                              input size_t       size);
    logic [3:0]  be;
    logic [31:0] data;
    case (size)
      SZ_BYTE: begin
        be   = 4'b0001 << addr_lo;
        data = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be   = addr_lo[1] ? 4'b1100 : 4'b0011;
        data = {2{wdata[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        data = wdata;
      end
    endcase
    return {be, data};
  endfunction

endpackage

// File: rtl/dmem_mmio_sync_fifo.sv
// Small synchronous FIFO for the console TX byte stream; DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [PW:0]      cnt_q;
  logic             do_push, do_pop;

  assign valid_o = cnt_q != '0;
  assign full_o  = cnt_q == FULL_CNT;
  assign count_o = cnt_q;
  assign data_o  = valid_o ? mem_q[rd_q] : '0;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & valid_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// RV32I data memory with byte/half/word access, fixed-latency responses and a small
// MMIO window (TOHOST, TX console FIFO, status, cycle counter).
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 4096,
  parameter int          LATENCY      = 1,
  parameter logic [31:0] MMIO_BASE    = 32'hFFFFFFF0,
  parameter int          TXFIFO_DEPTH = 8,
  parameter string       INIT_FILE    = ""
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_error_o,
  output logic        test_done_o,
  output logic [31:0] test_code_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i
);
  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int          CW      = $clog2(TXFIFO_DEPTH) + 1;
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] cyc_q, code_q;
  logic        done_q;
  logic [LATENCY:1] vld_pipe_q, err_pipe_q;
  logic [31:0]      rdata_pipe_q [LATENCY:1];

  size_t       sz;
  logic        mmio_hit, ram_hit, misalign, bad_size, err, tx_wr, acc, ok;
  logic        tx_full;
  logic [CW-1:0] tx_count;
  logic [AW-1:0] idx;
  logic [35:0] lanes;
  logic [31:0] mmio_rd, rdata_d;

  always_comb begin
    case (req_size_i)
      2'b00:   sz = SZ_BYTE;
      2'b01:   sz = SZ_HALF;
      default: sz = SZ_WORD;
    endcase
  end

  assign idx      = req_addr_i[AW+1:2];
  assign ram_hit  = {2'b00, req_addr_i[31:2]} < DEPTH_L;
  assign mmio_hit = req_addr_i[31:4] == MMIO_BASE[31:4];
  assign bad_size = req_size_i == 2'b11;
  assign misalign = (sz == SZ_HALF && req_addr_i[0]) ||
                    (sz == SZ_WORD && req_addr_i[1:0] != 2'b00);
  // MMIO decode takes priority; it only accepts aligned word accesses.
  assign err      = bad_size | misalign | (mmio_hit ? (sz != SZ_WORD) : ~ram_hit);

  // Only a legal TX push can stall; full is the pre-pop value.
  assign tx_wr       = req_write_i & mmio_hit & ~err & (req_addr_i[3:0] == OFF_TXDATA);
  assign req_ready_o = ~reset_i & ~(tx_wr & tx_full);
  assign acc         = req_valid_i & req_ready_o;
  assign ok          = acc & ~err;
  assign lanes       = store_lanes(req_wdata_i, req_addr_i[1:0], sz);

  always_comb begin
    case (req_addr_i[3:0])
      OFF_TOHOST: mmio_rd = code_q;
      OFF_TXSTAT: mmio_rd = {24'b0, 4'(tx_count), 3'b0, tx_full};
      OFF_CYCLES: mmio_rd = cyc_q;
      default:    mmio_rd = 32'b0;
    endcase
    rdata_d = 32'b0;
    if (!req_write_i && !err)
      rdata_d = load_extend(mmio_hit ? mmio_rd : mem_q[idx], req_addr_i[1:0], sz,
                            req_unsigned_i);
  end

  always_ff @(posedge clock_i) begin
    if (ok && req_write_i && !mmio_hit)
      for (int b = 0; b < 4; b++)
        if (lanes[32+b]) mem_q[idx][8*b +: 8] <= lanes[8*b +: 8];
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cyc_q      <= '0;
      done_q     <= 1'b0;
      code_q     <= '0;
      vld_pipe_q <= '0;
      err_pipe_q <= '0;
      for (int s = 1; s <= LATENCY; s++) rdata_pipe_q[s] <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (ok && req_write_i && mmio_hit && req_addr_i[3:0] == OFF_TOHOST && !done_q) begin
        done_q <= 1'b1;
        code_q <= req_wdata_i;
      end
      vld_pipe_q[1]   <= acc;
      err_pipe_q[1]   <= acc & err;
      rdata_pipe_q[1] <= acc ? rdata_d : 32'b0;
      for (int s = 2; s <= LATENCY; s++) begin
        vld_pipe_q[s]   <= vld_pipe_q[s-1];
        err_pipe_q[s]   <= err_pipe_q[s-1];
        rdata_pipe_q[s] <= rdata_pipe_q[s-1];
      end
    end
  end

  assign rsp_valid_o = vld_pipe_q[LATENCY] & ~reset_i;
  assign rsp_error_o = err_pipe_q[LATENCY] & ~reset_i;
  assign rsp_rdata_o = reset_i ? 32'b0 : rdata_pipe_q[LATENCY];
  assign test_done_o = done_q;
  assign test_code_o = code_q;

  sync_fifo #(.WIDTH(8), .DEPTH(TXFIFO_DEPTH)) u_txfifo (
    .clk_i   (clock_i),
    .rst_i   (reset_i),
    .push_i  (ok & tx_wr),
    .data_i  (req_wdata_i[7:0]),
    .pop_i   (tx_ready_i),
    .valid_o (tx_valid_o),
    .data_o  (tx_data_o),
    .full_o  (tx_full),
    .count_o (tx_count)
  );

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio at default parameters (LATENCY=1, 4096 words, 8-entry TX FIFO).
module tb_dmem_mmio;
  localparam logic [1:0] B = 2'd0, H = 2'd1, W = 2'd2, X = 2'd3;

  logic        clock = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0, tx_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = W;
  logic        req_ready, rsp_valid, rsp_error, test_done, tx_valid;
  logic [31:0] rsp_rdata, test_code;
  logic [7:0]  tx_data;
  int errors = 0, checks = 0;

  dmem_mmio dut (
    .clock_i(clock), .reset_i(reset), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_error), .test_done_o(test_done),
    .test_code_o(test_code), .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_ready_i(tx_ready)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Drives one request, waits (bounded) for acceptance, samples the response one cycle later.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] sz, input logic u,
                      output logic v, output logic [31:0] rd, output logic e);
    logic acc;
    acc = 1'b0;
    @(negedge clock);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_size = sz; req_unsigned = u;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (req_ready) begin acc = 1'b1; break; end
      @(negedge clock);
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL xact_accept addr=%h ready=%b required=1 within 20 cycles", a, req_ready);
      req_valid = 1'b0; v = 1'b0; rd = '0; e = 1'b0;
    end else begin
      @(posedge clock);
      #1 req_valid = 1'b0;
      @(negedge clock);
      v = rsp_valid; rd = rsp_rdata; e = rsp_error;
    end
  endtask

  task automatic test_reset();
    req_valid = 1'b1; req_addr = 32'h100; req_size = W; req_write = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ready ready=%b rsp_valid=%b required 0/0", req_ready, rsp_valid);
    end
    req_valid = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({rsp_valid, rsp_error, rsp_rdata, test_done, test_code, tx_valid, tx_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs v=%b e=%b rd=%h done=%b code=%h txv=%b txd=%h required all 0",
               rsp_valid, rsp_error, rsp_rdata, test_done, test_code, tx_valid, tx_data);
    end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got=%b required=1", req_ready); end
    req_valid = 1'b1; req_addr = 32'hFFFFFFFC; req_size = W;
    @(posedge clock); #1 req_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd0) begin
      errors++; $display("FAIL cycles_start v=%b rd=%h required 1/00000000", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_subword();
    logic v, e; logic [31:0] rd;
    xact(1'b1, 32'h100, 32'h11223344, W, 1'b0, v, rd, e);
    checks++;
    if (v !== 1'b1 || e !== 1'b0 || rd !== 32'd0) begin
      errors++; $display("FAIL sw_rsp v=%b e=%b rd=%h required 1/0/00000000", v, e, rd);
    end
    xact(1'b1, 32'h101, 32'h123456AA, B, 1'b0, v, rd, e);
    checks++;
    if (v !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL sb_rsp v=%b e=%b required 1/0", v, e); end
    xact(1'b0, 32'h100, 32'h0, W, 1'b0, v, rd, e);
    checks++;
    if (v !== 1'b1 || e !== 1'b0 || rd !== 32'h1122AA44) begin
      errors++; $display("FAIL lw_after_sb v=%b e=%b rd=%h required 1/0/1122aa44", v, e, rd);
    end
    @(negedge clock);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_pulse rsp_valid=%b required=0", rsp_valid); end
    xact(1'b1, 32'h102, 32'h9ABC5566, H, 1'b0, v, rd, e);
    xact(1'b0, 32'h100, 32'h0, W, 1'b0, v, rd, e);
    checks++;
    if (rd !== 32'h5566AA44 || e !== 1'b0) begin
      errors++; $display("FAIL lw_after_sh rd=%h e=%b required 5566aa44/0", rd, e);
    end
  endtask

  task automatic test_load_ext();
    logic v, e; logic [31:0] rd;
    logic [31:0] va [8] = '{32'h202, 32'h202, 32'h202, 32'h200, 32'h200, 32'h203, 32'h201, 32'h200};
    logic [1:0]  vs [8] = '{B, B, H, H, H, B, B, W};
    logic        vu [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] ve [8] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h00007F01,
                            32'h00007F01, 32'hFFFFFF80, 32'h0000007F, 32'h80FF7F01};
    xact(1'b1, 32'h200, 32'h80FF7F01, W, 1'b0, v, rd, e);
    for (int i = 0; i < 8; i++) begin
      xact(1'b0, va[i], 32'h0, vs[i], vu[i], v, rd, e);
      checks++;
      if (v !== 1'b1 || e !== 1'b0 || rd !== ve[i]) begin
        errors++;
        $display("FAIL load_ext[%0d] addr=%h sz=%0d u=%b rd=%h e=%b required %h/0",
                 i, va[i], vs[i], vu[i], rd, e, ve[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic v, e; logic [31:0] rd;
    logic        ew [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ea [9] = '{32'h201, 32'h102, 32'h4000, 32'h4000, 32'h100, 32'h100,
                            32'hFFFFFFF0, 32'hFFFFFFF0, 32'h80000000};
    logic [1:0]  es [9] = '{H, W, W, W, X, X, B, H, W};
    xact(1'b1, 32'h0, 32'h00C0FFEE, W, 1'b0, v, rd, e);
    for (int i = 0; i < 9; i++) begin
      xact(ew[i], ea[i], 32'hFFFFFFFF, es[i], 1'b0, v, rd, e);
      checks++;
      if (v !== 1'b1 || e !== 1'b1 || rd !== 32'd0) begin
        errors++;
        $display("FAIL err_case[%0d] addr=%h sz=%0d v=%b e=%b rd=%h required 1/1/00000000",
                 i, ea[i], es[i], v, e, rd);
      end
    end
    xact(1'b0, 32'h100, 32'h0, W, 1'b0, v, rd, e);
    checks++;
    if (rd !== 32'h5566AA44) begin errors++; $display("FAIL err_no_side_100 rd=%h required 5566aa44", rd); end
    xact(1'b0, 32'h0, 32'h0, W, 1'b0, v, rd, e);
    checks++;
    if (rd !== 32'h00C0FFEE) begin errors++; $display("FAIL err_no_wrap_0 rd=%h required 00c0ffee", rd); end
    xact(1'b1, 32'h3FFC, 32'hCAFEF00D, W, 1'b0, v, rd, e);
    xact(1'b0, 32'h3FFC, 32'h0, W, 1'b0, v, rd, e);
    checks++;
    if (rd !== 32'hCAFEF00D || e !== 1'b0) begin
      errors++; $display("FAIL last_word rd=%h e=%b required cafef00d/0", rd, e);
    end
  endtask

  task automatic test_tohost();
    logic v, e; logic [31:0] rd;
    checks++;
    if (test_done !== 1'b0) begin errors++; $display("FAIL tohost_initial done=%b required=0", test_done); end
    xact(1'b1, 32'hFFFFFFF0, 32'd1, W, 1'b0, v, rd, e);
    checks++;
    if (test_done !== 1'b1 || test_code !== 32'd1 || e !== 1'b0) begin
      errors++; $display("FAIL tohost_first done=%b code=%h e=%b required 1/00000001/0", test_done, test_code, e);
    end
    xact(1'b1, 32'hFFFFFFF0, 32'd7, W, 1'b0, v, rd, e);
    checks++;
    if (test_done !== 1'b1 || test_code !== 32'd1) begin
      errors++; $display("FAIL tohost_sticky done=%b code=%h required 1/00000001", test_done, test_code);
    end
    xact(1'b0, 32'hFFFFFFF0, 32'h0, W, 1'b0, v, rd, e);
    checks++;
    if (rd !== 32'd1) begin errors++; $display("FAIL tohost_read rd=%h required 00000001", rd); end
    xact(1'b0, 32'hFFFFFFF4, 32'h0, W, 1'b0, v, rd, e);
    checks++;
    if (rd !== 32'd0 || e !== 1'b0) begin errors++; $display("FAIL txdata_read rd=%h e=%b required 0/0", rd, e); end
    xact(1'b1, 32'hFFFFFFF8, 32'hFFFFFFFF, W, 1'b0, v, rd, e);
    checks++;
    if (e !== 1'b0 || v !== 1'b1) begin errors++; $display("FAIL txstat_write v=%b e=%b required 1/0", v, e); end
    xact(1'b0, 32'hFFFFFFF8, 32'h0, W, 1'b0, v, rd, e);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL txstat_empty rd=%h required 00000000", rd); end
  endtask

  task automatic test_txfifo();
    logic v, e, pend; logic [31:0] rd; int k;
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      xact(1'b1, 32'hFFFFFFF4, 32'hA5A5A510 + 32'(i), W, 1'b0, v, rd, e);
      checks++;
      if (v !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL tx_push[%0d] v=%b e=%b required 1/0", i, v, e); end
    end
    xact(1'b0, 32'hFFFFFFF8, 32'h0, W, 1'b0, v, rd, e);
    checks++;
    if (rd !== 32'h81 || tx_valid !== 1'b1 || tx_data !== 8'h10) begin
      errors++; $display("FAIL txstat_full rd=%h txv=%b txd=%h required 00000081/1/10", rd, tx_valid, tx_data);
    end
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'hFFFFFFF4; req_wdata = 32'hA5A5A518; req_size = W;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL tx_full_stall ready=%b required=0", req_ready); end
    @(negedge clock);
    tx_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL tx_no_bypass ready=%b required=0", req_ready); end
    k = 0;
    for (int n = 0; n < 30 && k < 9; n++) begin
      pend = 1'b0;
      if (tx_valid) begin
        checks++;
        if (tx_data !== 8'h10 + 8'(k)) begin
          errors++; $display("FAIL tx_order[%0d] data=%h required %h", k, tx_data, 8'h10 + 8'(k));
        end
        k++;
      end
      if (n == 1) begin
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL tx_ready_after_pop ready=%b required=1", req_ready); end
      end
      if (req_valid && req_ready) pend = 1'b1;
      @(posedge clock); #1;
      if (pend) req_valid = 1'b0;
      @(negedge clock); #1;
    end
    req_valid = 1'b0;
    checks++;
    if (k != 9 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL tx_drain popped=%0d txv=%b required 9/0", k, tx_valid);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h300; req_wdata = 32'hDEADBEEF; req_size = W;
    @(posedge clock); #1;
    req_write = 1'b0; req_wdata = 32'h0;
    @(negedge clock);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_store v=%b rd=%h ready=%b required 1/00000000/1", rsp_valid, rsp_rdata, req_ready);
    end
    @(posedge clock); #1 req_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL b2b_load v=%b rd=%h required 1/deadbeef", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_reset_inflight();
    logic v, e; logic [31:0] rd;
    xact(1'b1, 32'hFFFFFFF4, 32'h5A, W, 1'b0, v, rd, e);
    checks++;
    if (tx_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_tx txv=%b required=1", tx_valid); end
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h300; req_size = W;
    @(posedge clock); #1;
    req_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL inflight_drop v=%b ready=%b required 0/0", rsp_valid, req_ready);
    end
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({rsp_valid, rsp_error, rsp_rdata, test_done, test_code, tx_valid, tx_data} !== '0) begin
      errors++;
      $display("FAIL post_reset v=%b e=%b rd=%h done=%b code=%h txv=%b txd=%h required all 0",
               rsp_valid, rsp_error, rsp_rdata, test_done, test_code, tx_valid, tx_data);
    end
    req_valid = 1'b1; req_addr = 32'hFFFFFFFC; req_size = W;
    @(posedge clock); #1 req_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd0) begin
      errors++; $display("FAIL cycles_restart v=%b rd=%h required 1/00000000", rsp_valid, rsp_rdata);
    end
    xact(1'b0, 32'h300, 32'h0, W, 1'b0, v, rd, e);
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_persists rd=%h required deadbeef", rd); end
  endtask

  initial begin
    test_reset();
    test_subword();
    test_load_ext();
    test_errors();
    test_tohost();
    test_txfifo();
    test_back_to_back();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
